// File: rtl/avalon_burst_reader.sv
// Avalon-MM burst-read master: fetches a block of 32-bit samples into a FIFO and streams them out.
// Optional feature macro: UNDERRUN_CNT_EN (consumer-underrun cycle counter).
module avalon_burst_reader #(
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic [31:0] AM_ADDR,
   output logic [2:0]  AM_BURSTCOUNT,
   output logic        AM_READ,
   output logic [3:0]  AM_BYTEENABLE,
   input  logic        AM_WAITREQUEST,
   input  logic [31:0] AM_READDATA,
   input  logic        AM_READDATAVALID,
   input  logic        start,
   input  logic [31:0] start_address,
   input  logic [31:0] number_samples,
   output logic [31:0] sample_data,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        FINISHED,
   output logic [15:0] underrun_count
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {IDLE, CHECK, REQ, RECV, DRAIN, DONE} state_t;

   state_t            state;
   logic [31:0]       addr;
   logic [31:0]       remaining;
   logic [2:0]        beats;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [31:0]       mem [FIFO_DEPTH];

   logic              idle_c;
   logic              start_acc_c;
   logic              push_c;
   logic              pop_c;
   logic [2:0]        burst_c;
   logic [CNT_W-1:0]  free_c;
   logic [CNT_W-1:0]  count_nxt_c;
   logic [PTR_W-1:0]  rd_nxt_c;
   logic [31:0]       head_nxt_c;

   assign AM_BYTEENABLE = 4'hF;

   // FIFO bookkeeping; the next head is forwarded from readdata when the FIFO would otherwise be empty
   always_comb begin
      idle_c      = (state == IDLE) || (state == DONE);
      start_acc_c = start && idle_c;
      push_c      = (state == RECV) && AM_READDATAVALID;
      pop_c       = sample_valid && sample_ready;
      burst_c     = (remaining < 32'(BURST_LEN)) ? remaining[2:0] : 3'(BURST_LEN);
      free_c      = CNT_W'(FIFO_DEPTH) - count;
      count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
      rd_nxt_c    = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
      head_nxt_c  = (push_c && (rd_nxt_c == wr_ptr)) ? AM_READDATA : mem[rd_nxt_c];
   end

   always_ff @(posedge CLK) begin
      if (push_c) mem[wr_ptr] <= AM_READDATA;
   end

   // Registered output stage: valid tracks FIFO occupancy, data holds the head entry
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         sample_valid <= 1'b0;
         sample_data  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr       <= rd_nxt_c;
         count        <= count_nxt_c;
         sample_valid <= (count_nxt_c != '0);
         if (count_nxt_c != '0) sample_data <= head_nxt_c;
      end
   end

   // Transfer sequencer: one burst outstanding, issued only when the FIFO can absorb it
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state         <= IDLE;
         addr          <= '0;
         remaining     <= '0;
         beats         <= '0;
         AM_ADDR       <= '0;
         AM_BURSTCOUNT <= '0;
         AM_READ       <= 1'b0;
         FINISHED      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_acc_c) begin
                  addr      <= start_address;
                  remaining <= number_samples;
                  FINISHED  <= (number_samples == '0);
                  state     <= (number_samples == '0) ? DONE : CHECK;
               end
            end
            CHECK: begin
               if (32'(free_c) >= 32'(burst_c)) begin
                  AM_READ       <= 1'b1;
                  AM_ADDR       <= addr;
                  AM_BURSTCOUNT <= burst_c;
                  beats         <= burst_c;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (!AM_WAITREQUEST) begin
                  AM_READ <= 1'b0;
                  state   <= RECV;
               end
            end
            RECV: begin
               if (AM_READDATAVALID) begin
                  beats <= beats - 3'd1;
                  if (beats == 3'd1) begin
                     addr      <= addr + {27'd0, AM_BURSTCOUNT, 2'b00};
                     remaining <= remaining - 32'(AM_BURSTCOUNT);
                     state     <= (remaining == 32'(AM_BURSTCOUNT)) ? DRAIN : CHECK;
                  end
               end
            end
            DRAIN: begin
               if (count == '0) begin
                  FINISHED <= 1'b1;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UNDERRUN_CNT_EN
   // Counts busy cycles where the consumer wanted a sample that was not there
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         underrun_count <= '0;
      end else if (start_acc_c) begin
         underrun_count <= '0;
      end else if (sample_ready && !sample_valid && !idle_c && (underrun_count != 16'hFFFF)) begin
         underrun_count <= underrun_count + 16'd1;
      end
   end
`else
   assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_avalon_burst_reader.sv
// Scoreboard bench for avalon_burst_reader: random memory slave, random consumer, queue-based reference.
module tb_avalon_burst_reader;

   localparam int unsigned BL = 4;
   localparam int unsigned FD = 8;

   logic        CLK;
   logic        RESET;
   logic [31:0] AM_ADDR;
   logic [2:0]  AM_BURSTCOUNT;
   logic        AM_READ;
   logic [3:0]  AM_BYTEENABLE;
   logic        AM_WAITREQUEST;
   logic [31:0] AM_READDATA;
   logic        AM_READDATAVALID;
   logic        start;
   logic [31:0] start_address;
   logic [31:0] number_samples;
   logic [31:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;
   logic        FINISHED;
   logic [15:0] underrun_count;

   avalon_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .CLK(CLK), .RESET(RESET),
      .AM_ADDR(AM_ADDR), .AM_BURSTCOUNT(AM_BURSTCOUNT), .AM_READ(AM_READ),
      .AM_BYTEENABLE(AM_BYTEENABLE), .AM_WAITREQUEST(AM_WAITREQUEST),
      .AM_READDATA(AM_READDATA), .AM_READDATAVALID(AM_READDATAVALID),
      .start(start), .start_address(start_address), .number_samples(number_samples),
      .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .FINISHED(FINISHED), .underrun_count(underrun_count)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  cnt;
   } burst_t;

   logic [31:0] exp_samples[$];
   burst_t      exp_bursts[$];
   logic [31:0] beat_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int ready_mode = 0;
   int wait_rand = 0;
   int stall_left = 0;
   int beat_limit = 1 << 30;
   int beats_sent = 0;
   int req_count = 0;
   int stall_seen = 0;
   int occ = 0;
   int max_occ = 0;
   bit armed = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory contents seen by the slave: a simple function of the byte address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA5A5A5A0 + ((a - 32'h100) >> 2);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Avalon slave: checks each accepted request against the reference burst list, then returns beats
   initial begin : slave
      logic        p_rd;
      logic        p_wt;
      logic [31:0] p_addr;
      logic [2:0]  p_cnt;
      burst_t      b;
      p_rd = 0; p_wt = 0; p_addr = 0; p_cnt = 0;
      AM_WAITREQUEST = 1'b0;
      AM_READDATAVALID = 1'b0;
      AM_READDATA = '0;
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            beat_q.delete();
            AM_READDATAVALID = 1'b0;
            AM_WAITREQUEST = 1'b0;
            p_rd = 0;
            p_wt = 0;
            continue;
         end
         if (p_rd && p_wt) begin
            stall_seen++;
            check("hold_read", 32'(AM_READ), 32'd1);
            check("hold_addr", AM_ADDR, p_addr);
            check("hold_burstcount", 32'(AM_BURSTCOUNT), 32'(p_cnt));
         end
         if (AM_READ && !AM_WAITREQUEST) begin
            req_count++;
            if (exp_bursts.size() == 0) begin
               check("unexpected_request", AM_ADDR, 32'hFFFF_FFFF);
            end else begin
               b = exp_bursts.pop_front();
               check("burst_addr", AM_ADDR, b.addr);
               check("burst_count", 32'(AM_BURSTCOUNT), 32'(b.cnt));
            end
            for (int i = 0; i < int'(AM_BURSTCOUNT); i++)
               beat_q.push_back(mem_word(AM_ADDR + 32'(4 * i)));
         end
         p_rd = AM_READ; p_wt = AM_WAITREQUEST; p_addr = AM_ADDR; p_cnt = AM_BURSTCOUNT;
         @(posedge CLK);
         #1;
         if (AM_READ && stall_left > 0) begin
            AM_WAITREQUEST = 1'b1;
            stall_left--;
         end else begin
            AM_WAITREQUEST = (wait_rand != 0) && ($urandom_range(0, 2) == 0);
         end
         if (beat_q.size() > 0 && beats_sent < beat_limit &&
             (wait_rand == 0 || $urandom_range(0, 3) != 0)) begin
            AM_READDATAVALID = 1'b1;
            AM_READDATA = beat_q.pop_front();
            beats_sent++;
         end else begin
            AM_READDATAVALID = 1'b0;
            AM_READDATA = $urandom();
         end
      end
   end

   // Consumer ready: always, random, or never
   initial begin
      sample_ready = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         case (ready_mode)
            0:       sample_ready = 1'b1;
            1:       sample_ready = 1'($urandom_range(0, 1));
            default: sample_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: pops the sample scoreboard on each transfer and checks stream properties
   initial begin : monitor
      logic        pv;
      logic        pr;
      logic [31:0] pd;
      logic        push;
      logic        pop;
      pv = 0; pr = 0; pd = 0;
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            pv = 0;
            occ = 0;
            continue;
         end
         if (pv && !pr) begin
            check("stall_valid", 32'(sample_valid), 32'd1);
            check("stall_data", sample_data, pd);
         end
         if (armed)
            check("finished_early", 32'(FINISHED && (exp_samples.size() != 0)), 32'd0);
         push = AM_READDATAVALID;
         pop  = sample_valid && sample_ready;
         if (pop) begin
            if (exp_samples.size() == 0)
               check("unexpected_sample", sample_data, 32'hDEAD_BEEF ^ sample_data ^ 32'h1);
            else
               check("sample_data", sample_data, exp_samples.pop_front());
         end
         occ = occ + int'(push) - int'(pop);
         if (occ > max_occ) max_occ = occ;
         if (push) check("fifo_no_overflow", 32'(occ <= int'(FD)), 32'd1);
         pv = sample_valid; pr = sample_ready; pd = sample_data;
      end
   end

   task automatic check_reset_vals();
      check("rst_addr", AM_ADDR, 32'd0);
      check("rst_burstcount", 32'(AM_BURSTCOUNT), 32'd0);
      check("rst_read", 32'(AM_READ), 32'd0);
      check("rst_byteenable", 32'(AM_BYTEENABLE), 32'hF);
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_data", sample_data, 32'd0);
      check("rst_finished", 32'(FINISHED), 32'd0);
      check("rst_underrun", 32'(underrun_count), 32'd0);
   endtask

   // Reference model: expected samples and burst list follow directly from base and length
   task automatic begin_xfer(input logic [31:0] base, input logic [31:0] n);
      burst_t b;
      for (int i = 0; i < int'(n); i++) exp_samples.push_back(mem_word(base + 32'(4 * i)));
      for (int k = 0; k < int'(n); k += int'(BL)) begin
         b.addr = base + 32'(4 * k);
         b.cnt  = 3'(((int'(n) - k) < int'(BL)) ? (int'(n) - k) : int'(BL));
         exp_bursts.push_back(b);
      end
      start = 1'b1;
      start_address = base;
      number_samples = n;
      @(posedge CLK);
      #1;
      start = 1'b0;
      start_address = $urandom();
      number_samples = $urandom();
      if (n != 0) check("finished_cleared", 32'(FINISHED), 32'd0);
`ifdef UNDERRUN_CNT_EN
      check("underrun_cleared", 32'(underrun_count), 32'd0);
`endif
      armed = 1;
   endtask

   task automatic end_xfer();
      int t;
      t = 0;
      while (exp_samples.size() != 0 && t < 3000) begin
         @(posedge CLK);
         #1;
         t++;
      end
      check("samples_delivered", 32'(exp_samples.size()), 32'd0);
      exp_samples.delete();
      t = 0;
      while (!FINISHED && t < 20) begin
         @(posedge CLK);
         #1;
         t++;
      end
      check("finished", 32'(FINISHED), 32'd1);
      check("bursts_issued", 32'(exp_bursts.size()), 32'd0);
      exp_bursts.delete();
`ifndef UNDERRUN_CNT_EN
      check("underrun_tied", 32'(underrun_count), 32'd0);
`endif
      armed = 0;
   endtask

   task automatic xfer(input logic [31:0] base, input logic [31:0] n);
      begin_xfer(base, n);
      end_xfer();
   endtask

   initial begin : main
      logic [31:0] r;
      logic [31:0] base;
      int          t;
      RESET = 1'b0;
      start = 1'b0;
      start_address = '0;
      number_samples = '0;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_vals();
      RESET = 1'b1;
      @(posedge CLK);
      #1;

      // basic single burst
      xfer(32'h100, 32'd4);
      // short final burst
      xfer(32'h0, 32'd10);

      // waitrequest stall of three cycles
      stall_left = 3; stall_seen = 0; req_count = 0;
      xfer(32'h40, 32'd4);
      check("stall_cycles", 32'(stall_seen), 32'd3);
      check("stall_req_count", 32'(req_count), 32'd1);

      // backpressure: FIFO fills, then no more requests
      ready_mode = 2; max_occ = 0; req_count = 0;
      begin_xfer(32'h200, 32'd16);
      repeat (100) @(posedge CLK);
      #1;
      check("bp_max_occ", 32'(max_occ), 32'(FD));
      check("bp_req_count", 32'(req_count), 32'd2);
      check("bp_read_idle", 32'(AM_READ), 32'd0);
      check("bp_valid", 32'(sample_valid), 32'd1);
      ready_mode = 0;
      end_xfer();

      // zero length, then restart
      req_count = 0;
      begin_xfer(32'h0, 32'd0);
      repeat (10) @(posedge CLK);
      #1;
      check("zero_no_read", 32'(req_count), 32'd0);
      end_xfer();
      xfer(32'h80, 32'd2);

      // start while busy is ignored
      ready_mode = 1;
      begin_xfer(32'h300, 32'd12);
      repeat (5) @(posedge CLK);
      #1;
      start = 1'b1; start_address = 32'h900; number_samples = 32'd3;
      @(posedge CLK);
      #1;
      start = 1'b0;
      end_xfer();

      // reset in the middle of a burst
      ready_mode = 2; beat_limit = 2; beats_sent = 0;
      begin_xfer(32'h100, 32'd4);
      t = 0;
      while (beats_sent < 2 && t < 50) begin
         @(posedge CLK);
         #1;
         t++;
      end
      check("rst_mid_beats", 32'(beats_sent), 32'd2);
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_reset_vals();
      exp_samples.delete();
      exp_bursts.delete();
      armed = 0;
      beat_limit = 1 << 30;
      ready_mode = 0;
      RESET = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         check("post_rst_empty", 32'(sample_valid), 32'd0);
      end
      xfer(32'h500, 32'd5);

      // randomized transfers with random stalls, gaps and consumer pacing
      ready_mode = 1; wait_rand = 1;
      for (int k = 0; k < 14; k++) begin
         r = $urandom();
         base = (k % 5 == 4) ? 32'hFFFF_FFF0 : {r[31:2], 2'b00};
         xfer(base, 32'($urandom_range(1, 20)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
